// File: rtl/cam_cfg_pkg.sv
// Shared types and constants for the OV7670 configuration sequencer.
// Holds the FSM states, table markers and camera register addresses.
package cam_cfg_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_PWR,
    S_BOOT,
    S_FETCH,
    S_DECODE,
    S_ISSUE,
    S_WAIT_I2C,
    S_WAIT,
    S_DONE,
    S_ERROR
  } state_e;

  localparam logic [15:0] END_MARK   = 16'hFFFF;
  localparam logic [15:0] DELAY_MARK = 16'hFFF0;

  localparam logic [7:0] CLKRC = 8'h11;
  localparam logic [7:0] COM7  = 8'h12;
  localparam logic [7:0] COM3  = 8'h0C;
  localparam logic [7:0] COM10 = 8'h15;
  localparam logic [7:0] TSLB  = 8'h3A;
  localparam logic [7:0] COM14 = 8'h3E;
  localparam logic [7:0] COM15 = 8'h40;

  function automatic int max3(int a, int b, int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/cam_config_rom.sv
// Default OV7670 register table, synchronous read with 1-cycle latency.
// Entry 0 soft-resets the sensor and is followed by a settle delay.
module cam_config_rom
  import cam_cfg_pkg::*;
#(
  parameter int AW = 7
) (
  input  logic          clk,
  input  logic [AW-1:0] i_addr,
  output logic [15:0]   o_data
);

  logic [15:0] w_data;

  always_comb begin
    w_data = END_MARK;
    case (int'(i_addr))
      0:       w_data = {COM7, 8'h80};
      1:       w_data = DELAY_MARK;
      2:       w_data = {CLKRC, 8'h01};
      3:       w_data = {COM7, 8'h04};
      4:       w_data = {COM15, 8'hD0};
      5:       w_data = {COM3, 8'h00};
      6:       w_data = {COM14, 8'h00};
      7:       w_data = {TSLB, 8'h04};
      8:       w_data = {COM10, 8'h02};
      default: w_data = END_MARK;
    endcase
  end

  always_ff @(posedge clk) begin
    o_data <= w_data;
  end

endmodule

// File: rtl/cam_config_sequencer.sv
// Powers up the OV7670 and streams its register table to the SCCB master.
// One shared down-counter times the power, boot and delay-marker waits.
module cam_config_sequencer
  import cam_cfg_pkg::*;
#(
  parameter logic [7:0] DEV_ADDR     = 8'h42,
  parameter int         TABLE_DEPTH  = 128,
  parameter int         RST_HOLD_CYC = 100_000,
  parameter int         BOOT_CYC     = 300_000,
  parameter int         DELAY_CYC    = 1_000_000,
  parameter int         MAX_RETRY    = 3,
  parameter bit         INT_ROM      = 1'b0,
  localparam int        AW           = $clog2(TABLE_DEPTH)
) (
  input  logic          clk,
  input  logic          reset_,
  input  logic          start,
  output logic [AW-1:0] rom_addr,
  input  logic [15:0]   rom_data,
  output logic          i2c_valid,
  input  logic          i2c_ready,
  output logic [7:0]    i2c_dev,
  output logic [7:0]    i2c_reg,
  output logic [7:0]    i2c_wdata,
  input  logic          i2c_done,
  input  logic          i2c_nack,
  output logic          cam_pwdn,
  output logic          cam_rst_n,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [7:0]    index
);

  localparam int IW = AW + 1;
  localparam int CW = $clog2(max3(RST_HOLD_CYC, BOOT_CYC, DELAY_CYC) + 1);
  localparam int RW = $clog2(MAX_RETRY + 2);

  state_e        r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [IW-1:0] r_idx;
  logic [RW-1:0] r_retry;
  logic [7:0]    r_reg, r_val;
  logic          r_done, r_err;
  logic [15:0]   w_rom;
  logic          w_cnt_zero, w_end;

  generate
    if (INT_ROM) begin : g_rom
      cam_config_rom #(.AW(AW)) u_rom (
        .clk    (clk),
        .i_addr (rom_addr),
        .o_data (w_rom)
      );
    end else begin : g_ext
      assign w_rom = rom_data;
    end
  endgenerate

  assign w_cnt_zero = (r_cnt == '0);
  // Running past the last slot is handled as an END marker.
  assign w_end = (r_idx == IW'(TABLE_DEPTH)) || (w_rom == END_MARK);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_DONE, S_ERROR: if (start) w_next = S_PWR;
      S_PWR:    if (w_cnt_zero) w_next = S_BOOT;
      S_BOOT:   if (w_cnt_zero) w_next = S_FETCH;
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        if (w_end)                    w_next = S_DONE;
        else if (w_rom == DELAY_MARK) w_next = S_WAIT;
        else                          w_next = S_ISSUE;
      end
      S_ISSUE:  if (i2c_ready) w_next = S_WAIT_I2C;
      S_WAIT_I2C: begin
        if (i2c_done) begin
          if (!i2c_nack)                     w_next = S_FETCH;
          else if (r_retry < RW'(MAX_RETRY)) w_next = S_ISSUE;
          else                               w_next = S_ERROR;
        end
      end
      S_WAIT:   if (w_cnt_zero) w_next = S_FETCH;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_retry <= '0;
      r_reg   <= '0;
      r_val   <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      // Load N-1 on entry so the wait state lasts exactly N cycles.
      if (w_next != r_state) begin
        unique case (w_next)
          S_PWR:   r_cnt <= CW'(RST_HOLD_CYC - 1);
          S_BOOT:  r_cnt <= CW'(BOOT_CYC - 1);
          S_WAIT:  r_cnt <= CW'(DELAY_CYC - 1);
          default: ;
        endcase
      end else if (!w_cnt_zero) begin
        r_cnt <= r_cnt - CW'(1);
      end
      unique case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_idx   <= '0;
            r_retry <= '0;
          end
        end
        S_DECODE: begin
          if (w_next == S_ISSUE) begin
            r_reg <= w_rom[15:8];
            r_val <= w_rom[7:0];
          end else if (w_next == S_DONE) begin
            r_done <= 1'b1;
          end
        end
        S_WAIT_I2C: begin
          if (i2c_done) begin
            if (!i2c_nack) begin
              r_idx   <= r_idx + IW'(1);
              r_retry <= '0;
            end else if (w_next == S_ISSUE) begin
              r_retry <= r_retry + RW'(1);
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_WAIT:  if (w_cnt_zero) r_idx <= r_idx + IW'(1);
        default: ;
      endcase
    end
  end

  assign rom_addr  = r_idx[AW-1:0];
  assign i2c_valid = (r_state == S_ISSUE);
  assign i2c_dev   = DEV_ADDR;
  assign i2c_reg   = r_reg;
  assign i2c_wdata = r_val;
  assign cam_pwdn  = (r_state == S_IDLE);
  assign cam_rst_n = (r_state != S_IDLE) && (r_state != S_PWR);
  assign busy      = (r_state != S_IDLE) && (r_state != S_DONE)
                  && (r_state != S_ERROR);
  assign done      = r_done;
  assign error     = r_err;
  assign index     = 8'(r_idx);

endmodule
